// File: rtl/sdram_pkg.sv
// sdram_pkg: command and error encodings, mode register layout and timing constants shared by the SDRAM model.
package sdram_pkg;
    typedef enum logic [3:0] {
        CMD_LMR   = 4'b0000,
        CMD_REF   = 4'b0001,
        CMD_PRE   = 4'b0010,
        CMD_ACT   = 4'b0011,
        CMD_WR    = 4'b0100,
        CMD_RD    = 4'b0101,
        CMD_NOP   = 4'b0111,
        CMD_DESEL = 4'b1111
    } cmd_t;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_ACT_OPEN = 3'd1,
        ERR_NO_ROW   = 3'd2,
        ERR_WDATA    = 3'd3,
        ERR_NOT_IDLE = 3'd4,
        ERR_MODE     = 3'd5,
        ERR_TIMING   = 3'd6
    } err_t;

    typedef struct packed {
        logic [2:0] cl;
        logic [1:0] bl;
    } mode_t;

    localparam logic [3:0] T_RCD = 4'd2;
    localparam logic [3:0] T_RP  = 4'd2;
    localparam logic [3:0] T_RAS = 4'd5;
    localparam logic [3:0] T_WR  = 4'd2;
    localparam logic [3:0] T_RC  = 4'd7;

    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction
endpackage

// File: rtl/sdram_dev_if.sv
// sdram_dev_if: pin-level SDRAM device bus between a controller and the device model.
interface sdram_dev_if #(parameter int ROW_WIDTH = 12);
    logic                 cke;
    logic                 cs;
    logic                 ras;
    logic                 cas;
    logic                 we;
    logic [1:0]           dqm;
    logic [ROW_WIDTH-1:0] addr;
    logic [1:0]           ba;
    logic [15:0]          write_data;
    logic                 wr_en;
    logic [15:0]          read_data;

    modport sub (input cke, cs, ras, cas, we, dqm, addr, ba, write_data, wr_en, output read_data);
    modport ctrl (output cke, cs, ras, cas, we, dqm, addr, ba, write_data, wr_en, input read_data);
endinterface

// File: rtl/sdram_model_bank.sv
// sdram_model_bank: one bank's open row and pending auto-precharge; SDRAM_MODEL_TIMING_CHECK_EN adds
// tRCD/tRP/tRAS/tWR/tRC counters that flag violations without blocking the command.
module sdram_model_bank
    import sdram_pkg::*;
#(
    parameter int ROW_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 act,
    input  logic                 pre,
    input  logic                 rw,
    input  logic                 ap,
    input  logic                 last,
    input  logic                 wlast,
    input  logic [ROW_WIDTH-1:0] row_in,
    output logic                 open,
    output logic [ROW_WIDTH-1:0] row,
    output logic                 t_err
);
    logic ap_pend, close;

    // A single-beat command carries its own auto-precharge bit; longer bursts use the stored one.
    assign close = pre || (last && (rw ? ap : ap_pend));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open    <= 1'b0;
            row     <= '0;
            ap_pend <= 1'b0;
        end else if (act) begin
            open    <= 1'b1;
            row     <= row_in;
            ap_pend <= 1'b0;
        end else if (close) begin
            open    <= 1'b0;
            ap_pend <= 1'b0;
        end else if (rw) begin
            ap_pend <= ap;
        end
    end

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    logic [3:0] c_act, c_pre, c_wr;

    // Counters hold edges since the event and saturate, so an idle bank never trips a check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_act <= 4'hF;
            c_pre <= 4'hF;
            c_wr  <= 4'hF;
        end else if (en) begin
            c_act <= act ? 4'd1 : sat_inc(c_act);
            c_pre <= (close && open && !act) ? 4'd1 : sat_inc(c_pre);
            c_wr  <= wlast ? 4'd1 : sat_inc(c_wr);
        end
    end

    assign t_err = (rw && c_act < T_RCD)
                || (act && (c_pre < T_RP || c_act < T_RC))
                || (pre && open && (c_act < T_RAS || c_wr < T_WR));
`else
    logic unused_timing;
    assign unused_timing = ^{en, wlast};
    assign t_err = 1'b0;
`endif
endmodule

// File: rtl/sdram_model.sv
// sdram_model: cycle-accurate SDRAM device responder with burst engine, CL pipeline and protocol error flags.
// Optional timing checks are enabled by SDRAM_MODEL_TIMING_CHECK_EN (see sdram_model_bank).
module sdram_model
    import sdram_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int COL_WIDTH  = 9,
    parameter int ROW_WIDTH  = ADDR_WIDTH - COL_WIDTH - 3,
    parameter int MEM_AW     = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    sdram_dev_if.sub    dev,
    output logic        err,
    output logic [2:0]  err_code
);
    logic [3:0]           cmd, open, t_err;
    logic [ROW_WIDTH-1:0] rows [4];
    logic                 is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
    logic                 any_open, rw_ok, mode_bad, mode_ld;
    mode_t                mode;
    logic                 b_act, b_wr;
    logic [2:0]           b_left;
    logic [1:0]           b_bank;
    logic [ROW_WIDTH-1:0] b_row;
    logic [COL_WIDTH-1:0] b_col;
    logic                 beat_v, beat_wr, last, mem_we;
    logic [1:0]           beat_bank;
    logic [ROW_WIDTH-1:0] beat_row;
    logic [COL_WIDTH-1:0] beat_col, bl_mask, next_col;
    logic [MEM_AW-1:0]    idx;
    logic [15:0]          mem [1 << MEM_AW];
    logic                 p0_v, p1_v;
    logic [15:0]          p0_d, p1_d, rd_q;
    err_t                 ecode;

    assign cmd      = {dev.cs, dev.ras, dev.cas, dev.we};
    assign is_act   = dev.cke && cmd == CMD_ACT;
    assign is_rd    = dev.cke && cmd == CMD_RD;
    assign is_wr    = dev.cke && cmd == CMD_WR;
    assign is_pre   = dev.cke && cmd == CMD_PRE;
    assign is_ref   = dev.cke && cmd == CMD_REF;
    assign is_lmr   = dev.cke && cmd == CMD_LMR;
    assign any_open = |open;
    assign rw_ok    = (is_rd || is_wr) && open[dev.ba];
    assign mode_bad = !(dev.addr[6:4] == 3'd2 || dev.addr[6:4] == 3'd3) || dev.addr[2];
    assign mode_ld  = is_lmr && !any_open && !mode_bad;

    // An accepted READ/WRITE performs its beat 0 on its own edge and pre-empts any running burst.
    assign beat_v    = rw_ok || (dev.cke && b_act);
    assign beat_wr   = rw_ok ? is_wr : b_wr;
    assign beat_bank = rw_ok ? dev.ba : b_bank;
    assign beat_row  = rw_ok ? rows[dev.ba] : b_row;
    assign beat_col  = rw_ok ? dev.addr[COL_WIDTH-1:0] : b_col;
    assign last      = beat_v && (rw_ok ? mode.bl == 2'd0 : b_left == 3'd1);
    assign bl_mask   = COL_WIDTH'((4'd1 << mode.bl) - 4'd1);
    assign next_col  = (beat_col & ~bl_mask) | ((beat_col + COL_WIDTH'(1)) & bl_mask);
    assign idx       = MEM_AW'({beat_bank, beat_row, beat_col});
    assign mem_we    = beat_v && beat_wr && dev.wr_en;

    for (genvar i = 0; i < 4; i++) begin : g_bank
        sdram_model_bank #(.ROW_WIDTH(ROW_WIDTH)) u_bank (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (dev.cke),
            .act    (is_act && dev.ba == 2'(i)),
            .pre    (is_pre && (dev.addr[10] || dev.ba == 2'(i))),
            .rw     (rw_ok && dev.ba == 2'(i)),
            .ap     (dev.addr[10]),
            .last   (last && beat_bank == 2'(i)),
            .wlast  (last && beat_wr && beat_bank == 2'(i)),
            .row_in (dev.addr),
            .open   (open[i]),
            .row    (rows[i]),
            .t_err  (t_err[i])
        );
    end

    // Lowest code wins when several violations share an edge.
    assign ecode = (is_act && open[dev.ba])               ? ERR_ACT_OPEN :
                   ((is_rd || is_wr) && !open[dev.ba])    ? ERR_NO_ROW   :
                   (beat_v && beat_wr && !dev.wr_en)      ? ERR_WDATA    :
                   ((is_ref || is_lmr) && any_open)       ? ERR_NOT_IDLE :
                   (is_lmr && mode_bad)                   ? ERR_MODE     :
                   (|t_err)                               ? ERR_TIMING   : ERR_NONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err      <= 1'b0;
            err_code <= 3'd0;
            mode     <= '{cl: 3'd2, bl: 2'd0};
            b_act    <= 1'b0;
            b_wr     <= 1'b0;
            b_left   <= 3'd0;
            b_bank   <= 2'd0;
            b_row    <= '0;
            b_col    <= '0;
            p0_v     <= 1'b0;
            p1_v     <= 1'b0;
            p1_d     <= 16'd0;
            rd_q     <= 16'd0;
        end else begin
            err      <= ecode != ERR_NONE;
            err_code <= ecode;
            if (dev.cke) begin
                if (mode_ld) mode <= '{cl: dev.addr[6:4], bl: dev.addr[1:0]};
                if (rw_ok) begin
                    b_act  <= mode.bl != 2'd0;
                    b_left <= 3'((4'd1 << mode.bl) - 4'd1);
                    b_wr   <= is_wr;
                    b_bank <= dev.ba;
                    b_row  <= rows[dev.ba];
                    b_col  <= next_col;
                end else if (b_act) begin
                    b_act  <= b_left != 3'd1;
                    b_left <= b_left - 3'd1;
                    b_col  <= next_col;
                end
                p0_v <= beat_v && !beat_wr;
                p1_v <= p0_v;
                p1_d <= p0_d;
                rd_q <= (mode.cl == 3'd3) ? (p1_v ? p1_d : 16'd0) : (p0_v ? p0_d : 16'd0);
            end
        end
    end

    // Storage is deliberately left unreset so data survives a reset.
    always_ff @(posedge clk) begin
        if (mem_we && !dev.dqm[0]) mem[idx][7:0] <= dev.write_data[7:0];
        if (mem_we && !dev.dqm[1]) mem[idx][15:8] <= dev.write_data[15:8];
        if (beat_v && !beat_wr) p0_d <= mem[idx];
    end

    assign dev.read_data = rd_q;
endmodule

// File: tb/tb_sdram_model.sv
// tb_sdram_model: table-driven command vectors plus hand sequences for cke freeze, reset mid-burst and tRCD.
module tb_sdram_model;
    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101, WR = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010, REF = 4'b0001, LMR = 4'b0000;
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
    localparam logic [2:0] T_CODE = 3'd6;
`else
    localparam logic [2:0] T_CODE = 3'd0;
`endif

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [11:0] addr;
        logic [1:0]  dqm;
        logic [15:0] wd;
        logic        we;
        logic [15:0] rd;
        logic [2:0]  code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err;
    logic [2:0]  err_code;
    int          checks = 0;
    int          errors = 0;
    vec_t        v[$];

    sdram_dev_if #(.ROW_WIDTH(12)) dev ();

    sdram_model dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dev      (dev),
        .err      (err),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a, input logic [1:0] m,
                       input logic [15:0] wd, input logic we, input logic [15:0] rd, input logic [2:0] code);
        v.push_back('{c, b, a, m, wd, we, rd, code});
    endtask

    task automatic step(input logic [3:0] c, input logic [1:0] b, input logic [11:0] a, input logic [1:0] m,
                        input logic [15:0] wd, input logic we);
        @(negedge clk);
        {dev.cs, dev.ras, dev.cas, dev.we} = c;
        dev.ba = b;
        dev.addr = a;
        dev.dqm = m;
        dev.write_data = wd;
        dev.wr_en = we;
        @(posedge clk);
        #1;
    endtask

    initial begin
        dev.cke = 1'b1;
        {dev.cs, dev.ras, dev.cas, dev.we} = 4'b1111;
        dev.dqm = 2'b00;
        dev.addr = '0;
        dev.ba = 2'd0;
        dev.write_data = 16'd0;
        dev.wr_en = 1'b0;

        // CL=2 BL=1 write then read back
        add(LMR, 0, 12'h020, 0, 0, 0, 0, 0);
        add(ACT, 0, 12'h005, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(WR,  0, 12'h003, 0, 16'hA55A, 1, 0, 0);
        add(RD,  0, 12'h003, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 16'hA55A, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        // CL=3 BL=4 wrapped burst: columns 4..7 = 1..4, read from column 6
        add(PRE, 0, 12'h400, 0, 0, 0, 0, 0);
        add(LMR, 0, 12'h032, 0, 0, 0, 0, 0);
        add(ACT, 1, 12'h007, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(WR,  1, 12'h004, 0, 16'd1, 1, 0, 0);
        add(NOP, 0, 0, 0, 16'd2, 1, 0, 0);
        add(NOP, 0, 0, 0, 16'd3, 1, 0, 0);
        add(NOP, 0, 0, 0, 16'd4, 1, 0, 0);
        add(RD,  1, 12'h006, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 16'd3, 0);
        add(NOP, 0, 0, 0, 0, 0, 16'd4, 0);
        add(NOP, 0, 0, 0, 0, 0, 16'd1, 0);
        add(NOP, 0, 0, 0, 0, 0, 16'd2, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        // byte-lane masking
        add(PRE, 0, 12'h400, 0, 0, 0, 0, 0);
        add(LMR, 0, 12'h020, 0, 0, 0, 0, 0);
        add(ACT, 2, 12'h009, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(WR,  2, 12'h00A, 2'b00, 16'hFFFF, 1, 0, 0);
        add(WR,  2, 12'h00A, 2'b10, 16'h1234, 1, 0, 0);
        add(RD,  2, 12'h00A, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 16'hFF34, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        // read to closed bank
        add(RD,  3, 12'h000, 0, 0, 0, 0, 3'd2);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        // auto-precharge after a BL=2 write
        add(PRE, 0, 12'h400, 0, 0, 0, 0, 0);
        add(LMR, 0, 12'h021, 0, 0, 0, 0, 0);
        add(ACT, 0, 12'h001, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(WR,  0, 12'h400, 0, 16'h1111, 1, 0, 0);
        add(NOP, 0, 0, 0, 16'h2222, 1, 0, 0);
        add(RD,  0, 12'h000, 0, 0, 0, 0, 3'd2);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(ACT, 0, 12'h001, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(RD,  0, 12'h000, 0, 0, 0, 0, 0);
        add(NOP, 0, 0, 0, 0, 0, 16'h1111, 0);
        add(NOP, 0, 0, 0, 0, 0, 16'h2222, 0);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        // remaining error codes
        add(ACT, 0, 12'h002, 0, 0, 0, 0, 3'd1);
        add(REF, 0, 0, 0, 0, 0, 0, 3'd4);
        add(WR,  0, 12'h000, 0, 16'hBEEF, 0, 0, 3'd3);
        add(NOP, 0, 0, 0, 16'hBEEF, 0, 0, 3'd3);
        add(NOP, 0, 0, 0, 0, 0, 0, 0);
        add(PRE, 0, 12'h400, 0, 0, 0, 0, 0);
        add(LMR, 0, 12'h050, 0, 0, 0, 0, 3'd5);
        add(LMR, 0, 12'h024, 0, 0, 0, 0, 3'd5);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_rd", dev.read_data, 16'd0);
        chk("reset_err", {15'd0, err}, 16'd0);
        chk("reset_code", {13'd0, err_code}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < v.size(); i++) begin
            step(v[i].cmd, v[i].ba, v[i].addr, v[i].dqm, v[i].wd, v[i].we);
            chk($sformatf("vec%0d_rd", i), dev.read_data, v[i].rd);
            chk($sformatf("vec%0d_err", i), {15'd0, err}, {15'd0, v[i].code != 3'd0});
            chk($sformatf("vec%0d_code", i), {13'd0, err_code}, {13'd0, v[i].code});
        end

        // cke low freezes the read pipeline and holds read_data
        step(LMR, 0, 12'h020, 0, 0, 0);
        step(ACT, 2, 12'h009, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        step(RD, 2, 12'h00A, 0, 0, 0);
        chk("cke_rd0", dev.read_data, 16'd0);
        step(NOP, 0, 0, 0, 0, 0);
        chk("cke_beat", dev.read_data, 16'hFF34);
        dev.cke = 1'b0;
        step(RD, 2, 12'h00A, 0, 0, 0);
        chk("cke_hold1", dev.read_data, 16'hFF34);
        chk("cke_noerr", {15'd0, err}, 16'd0);
        step(NOP, 0, 0, 0, 0, 0);
        chk("cke_hold2", dev.read_data, 16'hFF34);
        dev.cke = 1'b1;
        step(NOP, 0, 0, 0, 0, 0);
        chk("cke_resume", dev.read_data, 16'd0);
        step(NOP, 0, 0, 0, 0, 0);
        chk("cke_ignored_rd", dev.read_data, 16'd0);
        step(NOP, 0, 0, 0, 0, 0);

        // reset in the middle of a CL=3 BL=4 read burst
        step(PRE, 0, 12'h400, 0, 0, 0);
        chk("pre_noerr", {13'd0, err_code}, 16'd0);
        step(LMR, 0, 12'h032, 0, 0, 0);
        step(ACT, 2, 12'h009, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        step(RD, 2, 12'h00A, 0, 0, 0);
        step(NOP, 0, 0, 0, 0, 0);
        chk("cl3_early", dev.read_data, 16'd0);
        step(NOP, 0, 0, 0, 0, 0);
        chk("cl3_beat0", dev.read_data, 16'hFF34);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_rd", dev.read_data, 16'd0);
        @(posedge clk);
        #1;
        chk("rst_next_rd", dev.read_data, 16'd0);
        chk("rst_next_err", {15'd0, err}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ACTIVE then READ on the next edge: tRCD violation only when timing checks are built in
        step(ACT, 2, 12'h009, 0, 0, 0);
        step(RD, 2, 12'h00A, 0, 0, 0);
        chk("trcd_code", {13'd0, err_code}, {13'd0, T_CODE});
        chk("trcd_err", {15'd0, err}, {15'd0, T_CODE != 3'd0});
        step(NOP, 0, 0, 0, 0, 0);
        chk("trcd_data", dev.read_data, 16'hFF34);
        chk("trcd_clear", {13'd0, err_code}, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
